// File: rtl/mem_bus_ctrl.sv
// Bus interface unit: turns byte/word core requests into single-byte memory strobes.
// Define MEM_BUS_CTRL_WORD_EN to honour req_word; without it every access is a byte access.
module mem_bus_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_word,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write_enable,
    output logic                mem_read_enable,
    output logic [DATA_W-1:0]   mem_data_in,
    input  logic [DATA_W-1:0]   mem_data_out
);

`ifdef MEM_BUS_CTRL_WORD_EN
    localparam logic WORD_EN = 1'b1;
`else
    localparam logic WORD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        WR1,
        RD0,
        RD1,
        RD_LAST,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2*DATA_W-1:0]   wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  word_q, word_d;
    logic [2*DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]     addr_inc;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_din_q, mem_din_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        word_d  = word_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    word_d  = req_word & WORD_EN;
                    rdata_d = '0;
                    state_d = req_write ? WR0 : RD0;
                end
            end
            WR0:     state_d = word_q ? WR1 : RESP;
            WR1:     state_d = RESP;
            RD0:     state_d = word_q ? RD1 : RD_LAST;
            RD1: begin
                rdata_d[DATA_W-1:0] = mem_data_out;
                state_d = RD_LAST;
            end
            RD_LAST: begin
                if (word_q) begin
                    rdata_d[2*DATA_W-1:DATA_W] = mem_data_out;
                end else begin
                    rdata_d = {{DATA_W{1'b0}}, mem_data_out};
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        addr_inc    = addr_d + {{(ADDR_W-1){1'b0}}, 1'b1};
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rsp_rdata_d = (state_d == RESP) ? rdata_d : '0;
        mem_we_d    = (state_d == WR0) || (state_d == WR1);
        mem_re_d    = (state_d == RD0) || (state_d == RD1);
        mem_addr_d  = '0;
        mem_din_d   = '0;
        case (state_d)
            WR0: begin
                mem_addr_d = addr_d;
                mem_din_d  = wdata_d[DATA_W-1:0];
            end
            WR1: begin
                mem_addr_d = addr_inc;
                mem_din_d  = wdata_d[2*DATA_W-1:DATA_W];
            end
            RD0:     mem_addr_d = addr_d;
            RD1:     mem_addr_d = addr_inc;
            default: mem_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            word_q      <= word_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    // Reset kills memory strobes and any pending response in the same cycle it rises.
    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q & ~rst;
    assign rsp_rdata        = rst ? '0 : rsp_rdata_q;
    assign mem_write_enable = mem_we_q & ~rst;
    assign mem_read_enable  = mem_re_q & ~rst;
    assign mem_addr         = rst ? '0 : mem_addr_q;
    assign mem_data_in      = rst ? '0 : mem_din_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a registered-read byte memory model.
// Expectations follow MEM_BUS_CTRL_WORD_EN the same way the design build does.
module tb_mem_bus_ctrl;

`ifdef MEM_BUS_CTRL_WORD_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_word = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out = '0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        bd_en = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    exp_t        rsp_exp[$];
    logic [23:0] wr_exp[$];
    logic [23:0] obs_wr[$];
    int          rd_cnt = 0;
    int          overlap_cnt = 0;
    bit          keep_ready = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    mem_bus_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_word         (req_word),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory model with one-cycle registered read, plus strobe monitor.
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (mem_write_enable) mem[mem_addr] <= mem_data_in;
        if (mem_read_enable) mem_data_out <= mem[mem_addr];
        if (mem_write_enable) obs_wr.push_back({mem_addr, mem_data_in});
        if (mem_read_enable) rd_cnt++;
        if (mem_write_enable && mem_read_enable) overlap_cnt++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic preload(input logic [15:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        bd_en = 1'b1; bd_addr = addr; bd_data = data;
        @(posedge clk); #1;
        bd_en = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic push_expect(input logic write, input logic word,
                               input logic [15:0] addr, input logic [15:0] wdata);
        exp_t        e;
        logic        eff_word;
        logic [15:0] a1;
        eff_word = word && WORD_EN;
        a1 = addr + 16'd1;
        if (write) begin
            ref_mem[addr] = wdata[7:0];
            wr_exp.push_back({addr, wdata[7:0]});
            if (eff_word) begin
                ref_mem[a1] = wdata[15:8];
                wr_exp.push_back({a1, wdata[15:8]});
            end
            e.rdata = 16'h0000;
            e.lat = eff_word ? 3 : 2;
        end else begin
            e.rdata = eff_word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
            e.lat = eff_word ? 4 : 3;
        end
        rsp_exp.push_back(e);
    endtask

    // Drives one request and returns #1 after its handshake edge.
    task automatic applyStimulus(input logic write, input logic word, input logic [15:0] addr,
                                 input logic [15:0] wdata, input bit expect_rsp);
        int n;
        bit ok;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = write; req_word = word;
        req_addr = addr; req_wdata = wdata;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (req_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL req_handshake: got no req_ready want req_ready=1 within 50 cycles");
        end else if (expect_rsp) begin
            push_expect(write, word, addr, wdata);
        end
    endtask

    task automatic wait_response(output int lat, output logic [15:0] rdata);
        int n;
        bit found;
        n = 0; found = 1'b0; lat = 0; rdata = 16'h0000;
        while (!found && n < 20) begin
            n++;
            @(negedge clk);
            if (rsp_valid === 1'b1) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (found) begin
            lat = n;
            rdata = rsp_rdata;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            if (!keep_ready) rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mem_write_enable, mem_read_enable} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_strobes: got %b want 00", {mem_write_enable, mem_read_enable});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL rst_req_ready: got %b want 1", req_ready);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL rst_rsp: got valid=%b rdata=%h want 0/0000", rsp_valid, rsp_rdata);
        end
        vectors++;
        if ({mem_write_enable, mem_read_enable, mem_addr, mem_data_in} !== 26'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_mem: got we=%b re=%b addr=%h din=%h want all 0",
                     mem_write_enable, mem_read_enable, mem_addr, mem_data_in);
        end
        obs_wr.delete();
    endtask

    task automatic test_byte_rw();
        exp_t        e;
        int          lat;
        logic [15:0] rd;
        logic [23:0] w_exp, w_got;
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h005A, 1'b1);
        wait_response(lat, rd);
        e = rsp_exp.pop_front();
        vectors++;
        if (lat != e.lat) begin
            miscompares++; $display("[TB] FAIL byte_wr_lat: got %0d want %0d", lat, e.lat);
        end
        vectors++;
        if (rd !== e.rdata) begin
            miscompares++; $display("[TB] FAIL byte_wr_rdata: got %h want %h", rd, e.rdata);
        end
        while (wr_exp.size() > 0) begin
            w_exp = wr_exp.pop_front();
            vectors++;
            if (obs_wr.size() == 0) begin
                miscompares++; $display("[TB] FAIL byte_wr_strobe: got none want %h", w_exp);
            end else begin
                w_got = obs_wr.pop_front();
                if (w_got !== w_exp) begin
                    miscompares++; $display("[TB] FAIL byte_wr_strobe: got %h want %h", w_got, w_exp);
                end
            end
        end
        vectors++;
        if (obs_wr.size() != 0) begin
            miscompares++; $display("[TB] FAIL byte_wr_extra: got %0d extra writes want 0", obs_wr.size());
        end
        obs_wr.delete();

        applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1);
        wait_response(lat, rd);
        e = rsp_exp.pop_front();
        vectors++;
        if (lat != e.lat) begin
            miscompares++; $display("[TB] FAIL byte_rd_lat: got %0d want %0d", lat, e.lat);
        end
        vectors++;
        if (rd !== e.rdata) begin
            miscompares++; $display("[TB] FAIL byte_rd_rdata: got %h want %h", rd, e.rdata);
        end
    endtask

    task automatic test_word_wrap();
        exp_t        e;
        int          lat;
        logic [15:0] rd;
        logic [23:0] w_exp, w_got;
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1'b1);
        wait_response(lat, rd);
        e = rsp_exp.pop_front();
        vectors++;
        if (lat != e.lat || rd !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL word_wr_rsp: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rd, e.lat, e.rdata);
        end
        while (wr_exp.size() > 0) begin
            w_exp = wr_exp.pop_front();
            vectors++;
            if (obs_wr.size() == 0) begin
                miscompares++; $display("[TB] FAIL word_wr_strobe: got none want %h", w_exp);
            end else begin
                w_got = obs_wr.pop_front();
                if (w_got !== w_exp) begin
                    miscompares++; $display("[TB] FAIL word_wr_strobe: got %h want %h", w_got, w_exp);
                end
            end
        end
        vectors++;
        if (obs_wr.size() != 0) begin
            miscompares++; $display("[TB] FAIL word_wr_extra: got %0d extra writes want 0", obs_wr.size());
        end
        obs_wr.delete();

        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        wait_response(lat, rd);
        e = rsp_exp.pop_front();
        vectors++;
        if (lat != e.lat) begin
            miscompares++; $display("[TB] FAIL word_rd_lat: got %0d want %0d", lat, e.lat);
        end
        vectors++;
        if (rd !== e.rdata) begin
            miscompares++; $display("[TB] FAIL word_rd_rdata: got %h want %h", rd, e.rdata);
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          n;
        int          lat;
        bit          found;
        logic [15:0] rd;
        logic [23:0] w_exp, w_got;
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        e = rsp_exp.pop_front();
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            n++;
            @(negedge clk);
            if (rsp_valid === 1'b1) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        vectors++;
        if (!found || n != e.lat) begin
            miscompares++; $display("[TB] FAIL bp_lat: got %0d (found=%0b) want %0d", n, found, e.lat);
        end
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b0;
        req_addr = 16'h2000; req_wdata = 16'h0077;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b rdata=%h req_ready=%b want 1/%h/0",
                         c, rsp_valid, rsp_rdata, req_ready, e.rdata);
            end
        end
        vectors++;
        if (obs_wr.size() != 0) begin
            miscompares++; $display("[TB] FAIL bp_ignored_req: got %0d writes want 0", obs_wr.size());
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
        push_expect(1'b1, 1'b0, 16'h2000, 16'h0077);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_response(lat, rd);
        e = rsp_exp.pop_front();
        vectors++;
        if (lat != e.lat || rd !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL bp_next_rsp: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rd, e.lat, e.rdata);
        end
        while (wr_exp.size() > 0) begin
            w_exp = wr_exp.pop_front();
            vectors++;
            if (obs_wr.size() == 0) begin
                miscompares++; $display("[TB] FAIL bp_next_strobe: got none want %h", w_exp);
            end else begin
                w_got = obs_wr.pop_front();
                if (w_got !== w_exp) begin
                    miscompares++; $display("[TB] FAIL bp_next_strobe: got %h want %h", w_got, w_exp);
                end
            end
        end
        obs_wr.delete();
    endtask

    task automatic test_reset_abort();
        bit rsp_seen;
        preload(16'h0100, 8'hA5);
        preload(16'h0101, 8'hA5);
        obs_wr.delete();
        applyStimulus(1'b1, 1'b1, 16'h0100, 16'h1122, 1'b0);
        if (WORD_EN) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_write_enable, mem_read_enable} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL abort_strobes: got %b want 00", {mem_write_enable, mem_read_enable});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
        rsp_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rsp_seen = 1'b1;
        end
        vectors++;
        if (rsp_seen) begin
            miscompares++; $display("[TB] FAIL abort_no_rsp: got rsp_valid=1 want 0");
        end
        if (WORD_EN) ref_mem[16'h0100] = 8'h22;
        vectors++;
        if (mem[16'h0100] !== ref_mem[16'h0100] || mem[16'h0101] !== ref_mem[16'h0101]) begin
            miscompares++;
            $display("[TB] FAIL abort_mem: got %h %h want %h %h", mem[16'h0100], mem[16'h0101],
                     ref_mem[16'h0100], ref_mem[16'h0101]);
        end
        vectors++;
        if (obs_wr.size() != (WORD_EN ? 1 : 0)) begin
            miscompares++;
            $display("[TB] FAIL abort_writes: got %0d want %0d", obs_wr.size(), WORD_EN ? 1 : 0);
        end
        obs_wr.delete();
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat;
        int          ov0;
        logic [15:0] rd;
        preload(16'h0000, 8'h3E);
        preload(16'h0001, 8'h0F);
        ov0 = overlap_cnt;
        keep_ready = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 16'(i), 16'h0000, 1'b1);
            wait_response(lat, rd);
            e = rsp_exp.pop_front();
            vectors++;
            if (lat != e.lat || rd !== e.rdata) begin
                miscompares++;
                $display("[TB] FAIL b2b_rd%0d: got lat=%0d rdata=%h want lat=%0d rdata=%h",
                         i, lat, rd, e.lat, e.rdata);
            end
        end
        keep_ready = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (overlap_cnt != ov0) begin
            miscompares++; $display("[TB] FAIL b2b_overlap: got %0d overlaps want 0", overlap_cnt - ov0);
        end
    endtask

    task automatic test_word_disabled();
        exp_t        e;
        int          lat;
        int          r0;
        logic [15:0] rd;
        preload(16'h0002, 8'h0E);
        preload(16'h0003, 8'h05);
        r0 = rd_cnt;
        applyStimulus(1'b0, 1'b1, 16'h0002, 16'h0000, 1'b1);
        wait_response(lat, rd);
        e = rsp_exp.pop_front();
        vectors++;
        if (rd !== e.rdata) begin
            miscompares++; $display("[TB] FAIL wcfg_rdata: got %h want %h", rd, e.rdata);
        end
        vectors++;
        if (lat != e.lat) begin
            miscompares++; $display("[TB] FAIL wcfg_lat: got %0d want %0d", lat, e.lat);
        end
        vectors++;
        if (rd_cnt - r0 != (WORD_EN ? 2 : 1)) begin
            miscompares++;
            $display("[TB] FAIL wcfg_strobes: got %0d want %0d", rd_cnt - r0, WORD_EN ? 2 : 1);
        end
    endtask

    initial begin
        $display("[TB] mem_bus_ctrl bench, word accesses %s", WORD_EN ? "enabled" : "disabled");
        test_reset();
        test_byte_rw();
        test_word_wrap();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_word_disabled();
        vectors++;
        if (overlap_cnt != 0) begin
            miscompares++; $display("[TB] FAIL strobe_overlap: got %0d want 0", overlap_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
